// File: rtl/scc_channel_mixer.sv
// -----------------------------------------------------------------------------
// scc_channel_mixer
//
// Purpose:
//   Mixes the time-slotted output of the 5-channel SCC tone generator into one
//   signed sample per frame. Each channel keeps the last wave-RAM sample the
//   generator stepped to. That sample is scaled by the channel volume, gated by
//   the channel enable, and summed over channels A..E. The sum is presented
//   once per frame with a one-cycle strobe.
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   reset        synchronous, active-high reset
//   active [2:0] time slot: 0..4 = channel A..E, 5 = mix close, 6..7 = idle
//   wave_update  generator wave-step flag for the current slot
//   wave_data    signed wave-RAM sample for the current slot
//   reg_volume   unsigned 4-bit volume of the current slot's channel
//   reg_enable   channel enable mask, bit n = channel n
//   sound_out    signed 11-bit mixed sample, registered
//   sound_valid  one-cycle strobe marking a new sound_out value
//
// Build option:
//   SCC_MIXER_ROUND_EN - when defined, the volume-scaled product is rounded
//   half-up before the divide by 16 instead of truncated toward -inf.
// -----------------------------------------------------------------------------
module scc_channel_mixer (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  active,
  input  logic        wave_update,
  input  logic [7:0]  wave_data,
  input  logic [3:0]  reg_volume,
  input  logic [4:0]  reg_enable,
  output logic [10:0] sound_out,
  output logic        sound_valid
);

  logic signed [7:0]  sample_q [0:4];
  logic signed [7:0]  ff_product;
  logic signed [10:0] ff_acc;
  logic               ff_frame_seen;

  logic signed [7:0]  cur_sample;
  logic               chan_en;
  logic signed [12:0] prod;
  logic signed [12:0] prod_adj;
  logic signed [7:0]  scaled;
  logic signed [10:0] product_ext;

  // Select the current channel's held sample and enable bit. Idle and close
  // slots produce a zero sample with the enable forced off.
  always_comb begin
    cur_sample = '0;
    chan_en    = 1'b0;
    case (active)
      3'd0: begin cur_sample = sample_q[0]; chan_en = reg_enable[0]; end
      3'd1: begin cur_sample = sample_q[1]; chan_en = reg_enable[1]; end
      3'd2: begin cur_sample = sample_q[2]; chan_en = reg_enable[2]; end
      3'd3: begin cur_sample = sample_q[3]; chan_en = reg_enable[3]; end
      3'd4: begin cur_sample = sample_q[4]; chan_en = reg_enable[4]; end
      default: begin cur_sample = '0; chan_en = 1'b0; end
    endcase
    // Bypass: a sample loaded this cycle is used in this cycle's product.
    if (wave_update && (active < 3'd5)) begin
      cur_sample = $signed(wave_data);
    end
  end

  always_comb begin
    prod = 13'(cur_sample) * 13'($signed({1'b0, reg_volume}));
`ifdef SCC_MIXER_ROUND_EN
    prod_adj = prod + 13'sd8;
`else
    prod_adj = prod;
`endif
    // Product range is -1920..1913 after rounding, so the shifted value always
    // fits in 8 signed bits (-120..119).
    scaled = 8'(prod_adj >>> 4);
  end

  assign product_ext = {{3{ff_product[7]}}, ff_product};

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 5; i++) begin
        sample_q[i] <= '0;
      end
      ff_product    <= '0;
      ff_acc        <= '0;
      ff_frame_seen <= 1'b0;
      sound_out     <= '0;
      sound_valid   <= 1'b0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (wave_update && (active == 3'(i))) begin
          sample_q[i] <= $signed(wave_data);
        end
      end

      ff_product <= chan_en ? scaled : 8'sd0;

      // The accumulator runs one slot behind the product stage: the active==1
      // cycle sees channel A's product and restarts the frame.
      case (active)
        3'd1: begin
          ff_acc        <= product_ext;
          ff_frame_seen <= 1'b1;
        end
        3'd2, 3'd3, 3'd4: ff_acc <= ff_acc + product_ext;
        default: ff_acc <= ff_acc;
      endcase

      // The close slot folds in channel E, still in ff_product.
      if (active == 3'd5) begin
        sound_out   <= ff_acc + product_ext;
        sound_valid <= ff_frame_seen;
      end else begin
        sound_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/scc_channel_mixer.md
Name: scc_channel_mixer

Overview:
Downstream consumer of the 5-channel SCC tone generator's time-slotted output.
- Per time slot, it takes the wave-RAM sample read at the generator's wave address.
- It holds one sample per channel and updates it only when the generator flags a wave step.
- It scales each held sample by the channel's 4-bit volume, gates it by the channel enable, and sums channels A..E into one signed mix word per frame.
- It feeds the audio output / DAC stage.

Parameters:
- none (all widths fixed by SCC format)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- active  input  3  time slot: 0..4 = channel A..E, 5 = mix close, 6..7 = idle
- wave_update  input  1  generator wave-step flag for the current slot
- wave_data  input  8  signed wave-RAM sample for the current slot, valid in the same cycle as active
- reg_volume  input  4  unsigned volume of the current slot's channel
- reg_enable  input  5  channel enable mask, bit n = channel n
- sound_out  output  11  signed mixed sample, registered
- sound_valid  output  1  one-cycle strobe: new sound_out value

Behaviour:
Interface:
- One clock, clk; reset is synchronous and active-high.
- All state changes on the rising edge of clk.

Reset (reset=1 at a rising edge):
- Clears the five sample latches, ff_product, ff_acc, ff_frame_seen, sound_out and sound_valid to 0.
- Overrides every other input.

Sample latches (one per channel):
- Channel n loads wave_data when active==n and wave_update==1; otherwise it holds.
- cur_sample = wave_data if loading this cycle, else the latch value (bypass).

Product (product stage, cycle active==n, n=0..4):
- prod = cur_sample (signed 8b) × {1'b0, reg_volume} (signed 5b) → 13b signed.
- Range is -1920..1905.
- scaled = prod >>> 4 (arithmetic shift) → 8b signed, range -120..119.
- ff_product <= reg_enable[n] ? scaled : 0.
- When active is 5..7, ff_product <= 0.

Accumulate (accumulate stage, uses the product from the previous cycle):
- In cycle active==1: ff_acc <= sext(ff_product), which restarts the frame with channel A; ff_frame_seen <= 1.
- In cycles active==2..4: ff_acc <= ff_acc + sext(ff_product).
- In all other cycles: ff_acc holds.
- Width is 11b signed; the maximum magnitude of 600 cannot overflow.

Output (cycle active==5):
- sound_out <= ff_acc + sext(ff_product), i.e. channels A..E.
- sound_valid <= ff_frame_seen.
- In every other cycle, sound_valid <= 0 and sound_out holds.
- Latency: sound_out is valid in the cycle after active==5, normally the active==6 cycle. It is stable until the next frame.

Boundary conditions:
- Slots may dwell or skip. The accumulator restarts only on the cycle after active==0. A slot repeated on consecutive cycles is added each time; the upstream sequencer guarantees one cycle per slot.
- If reset is asserted mid-frame, ff_frame_seen=0. The first active==5 after reset gives no sound_valid unless slot 0 has been seen since reset.
- reg_volume==0 or a disabled channel contributes exactly 0. Its sample latch still updates.
- wave_update in slots 5..7 is ignored.

Optional Feature:
Macro SCC_MIXER_ROUND_EN.
- Defined: scaled = (prod + 8) >>> 4, giving round-half-up. The range stays -120..119.
- Undefined: truncating arithmetic shift as above.
- Nothing else changes.

Test Plan:
- Frame with all channels enabled, each slot wave_update=1, wave_data=8'h40, reg_volume=15 → sound_out=11'd300, sound_valid=1 for exactly one cycle (active==6 cycle).
- Same frame with wave_data=8'h80, volume 15 → sound_out=-600 (11'h5A8).
- Load 8'h40 on all channels, then next frame with wave_update=0 and wave_data=8'h10 → sound_out stays 300 (held samples used); reg_enable=5'b00001 → 60.
- wave_data=8'h01, volume 8, all enabled → sound_out=0 without SCC_MIXER_ROUND_EN, =5 with it.
- Assert reset during active==2, release, start sequence at active==3 → no sound_valid at that frame's close; next full 0..5 frame → sound_valid=1 with correct sum.
- Channel C reg_volume=0, others 8'h40 at volume 15 → sound_out=240.
